// File: rtl/alu_pkg.sv
// Shared definitions for the ARM-style data-processing ALU.
//   alu_op_e  : 4-bit ARM data-processing opcode encoding
//   is_arith(): true for opcodes that route through the shared adder
package alu_pkg;

    typedef enum logic [3:0] {
        OP_AND = 4'h0,
        OP_EOR = 4'h1,
        OP_SUB = 4'h2,
        OP_RSB = 4'h3,
        OP_ADD = 4'h4,
        OP_ADC = 4'h5,
        OP_SBC = 4'h6,
        OP_RSC = 4'h7,
        OP_TST = 4'h8,
        OP_TEQ = 4'h9,
        OP_CMP = 4'hA,
        OP_CMN = 4'hB,
        OP_ORR = 4'hC,
        OP_MOV = 4'hD,
        OP_BIC = 4'hE,
        OP_MVN = 4'hF
    } alu_op_e;

    function automatic logic is_arith(alu_op_e op);
        return op inside {OP_SUB, OP_RSB, OP_ADD, OP_ADC, OP_SBC, OP_RSC, OP_CMP, OP_CMN};
    endfunction

endpackage

// File: rtl/arm_alu_if.sv
// Operand/result bundle of the ALU.
//   A, B  : operands (bit 0 = MSB)      OP : opcode (bit 0 = MSB)
//   Ci    : carry-in (CPSR C)
//   Y     : registered result           N, Z, V, Co : registered flags
// master drives operands (issuing side), slave is the ALU.
interface arm_alu_if #(
    parameter int unsigned WIDTH = 32
);
    logic signed [0:WIDTH-1] A;
    logic signed [0:WIDTH-1] B;
    logic        [0:3]       OP;
    logic                    Ci;
    logic signed [0:WIDTH-1] Y;
    logic                    N;
    logic                    Z;
    logic                    V;
    logic                    Co;

    modport master (output A, B, OP, Ci, input  Y, N, Z, V, Co);
    modport slave  (input  A, B, OP, Ci, output Y, N, Z, V, Co);
endinterface

// File: rtl/alu_adder32.sv
// Combinational adder shared by all arithmetic opcodes.
//   i_x, i_y : adder inputs (already inverted by the caller where needed)
//   i_cin    : carry-in
//   o_sum    : low WIDTH bits of the sum
//   o_cout   : bit WIDTH of the sum (NOT borrow for subtracts)
//   o_ovf    : signed overflow
module alu_adder32 #(
    parameter int unsigned WIDTH = 32
) (
    input  logic [WIDTH-1:0] i_x,
    input  logic [WIDTH-1:0] i_y,
    input  logic             i_cin,
    output logic [WIDTH-1:0] o_sum,
    output logic             o_cout,
    output logic             o_ovf
);
    logic [WIDTH:0] w_sum;

    assign w_sum  = {1'b0, i_x} + {1'b0, i_y} + {{WIDTH{1'b0}}, i_cin};
    assign o_sum  = w_sum[WIDTH-1:0];
    assign o_cout = w_sum[WIDTH];
    // Inputs agree in sign but the result does not.
    assign o_ovf  = (i_x[WIDTH-1] == i_y[WIDTH-1]) && (w_sum[WIDTH-1] != i_x[WIDTH-1]);
endmodule

// File: rtl/arm_alu.sv
// ARM data-processing ALU with registered result and flags (one cycle latency).
//   clk   : rising-edge clock
//   rst_n : asynchronous active-low reset, clears Y and all flags
//   bus   : operand/result bundle (slave side)
module arm_alu
    import alu_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic       clk,
    input  logic       rst_n,
    arm_alu_if.slave   bus
);
    logic [WIDTH-1:0] w_a;
    logic [WIDTH-1:0] w_b;
    alu_op_e          w_op;
    logic             w_ci;

    logic [WIDTH-1:0] w_x;
    logic [WIDTH-1:0] w_y;
    logic             w_cin;
    logic [WIDTH-1:0] w_sum;
    logic             w_cout;
    logic             w_ovf;

    logic [WIDTH-1:0] w_res;
    logic             w_arith;
    logic             w_v;
    logic             w_co;

    logic [WIDTH-1:0] r_y;
    logic             r_n;
    logic             r_z;
    logic             r_v;
    logic             r_co;

    // Bit 0 of the bus vectors is the MSB, so a whole-vector copy keeps numeric value.
    assign w_a  = bus.A;
    assign w_b  = bus.B;
    assign w_op = alu_op_e'(bus.OP);
    assign w_ci = bus.Ci;

    // Every arithmetic opcode is x + y + cin with optional operand swap/inversion.
    always_comb begin
        w_x   = w_a;
        w_y   = w_b;
        w_cin = 1'b0;
        case (w_op)
            OP_SUB, OP_CMP: begin
                w_y   = ~w_b;
                w_cin = 1'b1;
            end
            OP_RSB: begin
                w_x   = w_b;
                w_y   = ~w_a;
                w_cin = 1'b1;
            end
            OP_ADC: w_cin = w_ci;
            OP_SBC: begin
                w_y   = ~w_b;
                w_cin = w_ci;
            end
            OP_RSC: begin
                w_x   = w_b;
                w_y   = ~w_a;
                w_cin = w_ci;
            end
            default: ;
        endcase
    end

    alu_adder32 #(
        .WIDTH (WIDTH)
    ) u_adder (
        .i_x    (w_x),
        .i_y    (w_y),
        .i_cin  (w_cin),
        .o_sum  (w_sum),
        .o_cout (w_cout),
        .o_ovf  (w_ovf)
    );

    always_comb begin
        w_res = w_sum;
        case (w_op)
            OP_AND, OP_TST: w_res = w_a & w_b;
            OP_EOR, OP_TEQ: w_res = w_a ^ w_b;
            OP_ORR:         w_res = w_a | w_b;
            OP_MOV:         w_res = w_b;
            OP_BIC:         w_res = w_a & ~w_b;
            OP_MVN:         w_res = ~w_b;
            default:        ;
        endcase
    end

    // Logical opcodes pass the incoming carry through and never overflow.
    assign w_arith = is_arith(w_op);
    assign w_v     = w_arith ? w_ovf  : 1'b0;
    assign w_co    = w_arith ? w_cout : w_ci;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_y  <= '0;
            r_n  <= 1'b0;
            r_z  <= 1'b0;
            r_v  <= 1'b0;
            r_co <= 1'b0;
        end else begin
            r_y  <= w_res;
            r_n  <= w_res[WIDTH-1];
            r_z  <= (w_res == '0);
            r_v  <= w_v;
            r_co <= w_co;
        end
    end

    assign bus.Y  = r_y;
    assign bus.N  = r_n;
    assign bus.Z  = r_z;
    assign bus.V  = r_v;
    assign bus.Co = r_co;
endmodule

// File: tb/tb_arm_alu.sv
// Self-checking bench for arm_alu: directed cases plus randomized operations
// checked against an arithmetic reference model.
module tb_arm_alu;
    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    arm_alu_if #(.WIDTH(32)) u_if ();

    arm_alu #(
        .WIDTH (32)
    ) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (u_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Observed outputs packed as {Y, N, Z, V, Co}.
    function automatic logic [35:0] observed();
        return {u_if.Y, u_if.N, u_if.Z, u_if.V, u_if.Co};
    endfunction

    task automatic check(input string tag, input logic [35:0] got, input logic [35:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got Y=%h NZVC=%b, expected Y=%h NZVC=%b",
                     tag, got[35:4], got[3:0], exp[35:4], exp[3:0]);
        end
    endtask

    // Reference model: opcode semantics written as plain signed/unsigned arithmetic.
    function automatic logic [35:0] model(input logic [31:0] a, input logic [31:0] b,
                                          input logic [3:0] op, input logic ci);
        longint    ua, ub, sa, sb, uu, ss;
        logic [31:0] y;
        logic        v, co, arith, is_sub;
        ua = longint'({32'd0, a});
        ub = longint'({32'd0, b});
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        arith  = 1'b1;
        is_sub = 1'b0;
        uu = 0;
        ss = 0;
        y  = 32'd0;
        case (op)
            4'h0, 4'h8: begin y = a & b;  arith = 1'b0; end
            4'h1, 4'h9: begin y = a ^ b;  arith = 1'b0; end
            4'hC:       begin y = a | b;  arith = 1'b0; end
            4'hD:       begin y = b;      arith = 1'b0; end
            4'hE:       begin y = a & ~b; arith = 1'b0; end
            4'hF:       begin y = ~b;     arith = 1'b0; end
            4'h2, 4'hA: begin uu = ua - ub; ss = sa - sb; is_sub = 1'b1; end
            4'h3:       begin uu = ub - ua; ss = sb - sa; is_sub = 1'b1; end
            4'h4, 4'hB: begin uu = ua + ub; ss = sa + sb; end
            4'h5:       begin uu = ua + ub + ci; ss = sa + sb + ci; end
            4'h6: begin
                uu = ua - ub - 1 + ci; ss = sa - sb - 1 + ci; is_sub = 1'b1;
            end
            default: begin
                uu = ub - ua - 1 + ci; ss = sb - sa - 1 + ci; is_sub = 1'b1;
            end
        endcase
        if (arith) begin
            y  = uu[31:0];
            // Subtract carry is NOT borrow; add carry is unsigned overflow.
            co = is_sub ? (uu >= 0) : (uu > 64'sd4294967295);
            v  = (ss > 64'sd2147483647) || (ss < -64'sd2147483648);
        end else begin
            co = ci;
            v  = 1'b0;
        end
        return {y, y[31], (y == 32'd0), v, co};
    endfunction

    task automatic do_op(input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] op, input logic ci);
        @(negedge clk);
        u_if.A  = a;
        u_if.B  = b;
        u_if.OP = op;
        u_if.Ci = ci;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] pick_operand();
        case ($urandom_range(0, 7))
            0: return 32'h0000_0000;
            1: return 32'h7FFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'hFFFF_FFFF;
            4: return 32'(($urandom_range(0, 1) == 0) ? 1 : 2);
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [31:0] a, b;
        logic [3:0]  op;
        logic        ci;
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        u_if.A   = '0;
        u_if.B   = '0;
        u_if.OP  = '0;
        u_if.Ci  = 1'b0;

        #3;
        check("reset_state", observed(), 36'h0);
        @(negedge clk);
        rst_n = 1'b1;

        do_op(32'hFFFF_FFF0, 32'h0000_000F, 4'h0, 1'b0);
        check("and_zero", observed(), {32'h0000_0000, 4'b0100});
        do_op(32'd10, 32'd15, 4'h4, 1'b0);
        check("add_small", observed(), {32'd25, 4'b0000});
        do_op(32'h7FFF_FFFF, 32'h1, 4'h4, 1'b0);
        check("add_ovf", observed(), {32'h8000_0000, 4'b1010});
        do_op(32'd6, 32'd8, 4'h7, 1'b1);
        check("rsc_pos", observed(), {32'd2, 4'b0001});
        do_op(32'd8, 32'd5, 4'h7, 1'b0);
        check("rsc_neg", observed(), {32'hFFFF_FFFC, 4'b1000});
        do_op(32'd0, 32'd0, 4'h8, 1'b1);
        check("tst_zero", observed(), {32'd0, 4'b0101});
        do_op(32'd0, 32'd0, 4'h9, 1'b1);
        check("teq_zero", observed(), {32'd0, 4'b0101});
        do_op(32'd5, 32'd5, 4'h2, 1'b0);
        check("sub_equal", observed(), {32'd0, 4'b0101});
        do_op(32'h8000_0000, 32'h1, 4'hA, 1'b0);
        check("cmp_ovf", observed(), {32'h7FFF_FFFF, 4'b0011});

        // Asynchronous reset mid-cycle with nonzero outputs.
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset", observed(), 36'h0);
        @(posedge clk);
        #1;
        check("reset_hold", observed(), 36'h0);
        @(negedge clk);
        rst_n = 1'b1;
        do_op(32'd1, 32'd1, 4'h4, 1'b0);
        check("post_reset_add", observed(), {32'd2, 4'b0000});

        for (int i = 0; i < 400; i++) begin
            a  = pick_operand();
            b  = pick_operand();
            op = 4'($urandom_range(0, 15));
            ci = 1'($urandom_range(0, 1));
            do_op(a, b, op, ci);
            check($sformatf("rand%0d op=%h a=%h b=%h ci=%b", i, op, a, b, ci),
                  observed(), model(a, b, op, ci));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
